// File: rtl/mem_arbiter_nch.sv
// mem_arbiter_nch: round-robin byte-serial memory arbiter
// NCH request channels onto one 8-bit RAM/IO bus
module mem_arbiter_nch #(
  parameter int NCH = 2,
  parameter logic [NCH-1:0] FLUSH_MASK = {NCH{1'b1}}
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              clr_in,
  input  logic              io_buffer_full,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [31:0]       mem_a,
  output logic              mem_wr,
  input  logic [NCH-1:0]    req_valid,
  input  logic [NCH-1:0]    req_wr,
  input  logic [2*NCH-1:0]  req_len,
  input  logic [32*NCH-1:0] req_addr,
  input  logic [32*NCH-1:0] req_data,
  output logic [NCH-1:0]    req_ready,
  output logic [NCH-1:0]    rsp_valid,
  output logic [31:0]       rsp_data,
  output logic              busy
);

  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    LAST
  } state_t;

  state_t        state;
  logic [CW-1:0] rr_ptr;
  logic [CW-1:0] ch;
  logic [CW-1:0] gnt_ch;
  logic [CW-1:0] cand;
  logic          found;
  logic [NCH-1:0] blk;
  logic [NCH-1:0] gnt;

  logic [31:0] addr;
  logic [31:0] dat;
  logic [31:0] rbuf;
  logic [31:0] rbuf_nxt;
  logic [31:0] cur_a;
  logic [31:0] sel_addr;
  logic [31:0] sel_data;
  logic [1:0]  sel_len;
  logic [1:0]  sel_last;
  logic        sel_wr;
  logic [1:0]  idx;
  logic [1:0]  last;
  logic [1:0]  pidx;
  logic        wr;
  logic        pend;
  logic        io_stall;
  logic        abort;

  // reads on masked channels may not start while a flush is pending
  assign blk = {NCH{clr_in}} & FLUSH_MASK & ~req_wr;

  // round-robin search starting just after the last granted channel
  always_comb begin
    gnt    = '0;
    gnt_ch = '0;
    cand   = '0;
    found  = 1'b0;
    for (int i = 1; i <= NCH; i++) begin
      cand = CW'((int'(rr_ptr) + i) % NCH);
      if (!found && req_valid[cand] && !blk[cand]) begin
        found  = 1'b1;
        gnt_ch = cand;
      end
    end
    if (found && state == IDLE && rdy_in && rst_in)
      gnt[gnt_ch] = 1'b1;
  end

  assign req_ready = gnt;

  // mux out the request fields of the winning channel
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    sel_len  = '0;
    sel_wr   = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      if (gnt_ch == CW'(c)) begin
        sel_addr = req_addr[32*c +: 32];
        sel_data = req_data[32*c +: 32];
        sel_len  = req_len[2*c +: 2];
        sel_wr   = req_wr[c];
      end
    end
  end

  assign sel_last = (sel_len == 2'd0) ? 2'd0 :
                    (sel_len == 2'd1) ? 2'd1 : 2'd3;

  assign cur_a    = addr + {30'd0, idx};
  assign io_stall = io_buffer_full && (cur_a[17:16] == 2'b11);
  assign abort    = clr_in && !wr && FLUSH_MASK[ch];

  assign busy     = (state != IDLE);
  assign mem_a    = (state == XFER) ? cur_a : '0;
  assign mem_wr   = (state == XFER) && wr && rdy_in && !io_stall;
  assign mem_dout = (state == XFER && wr) ?
                    dat[{idx, 3'b000} +: 8] : '0;

  // merge the byte answering last cycle's read address
  always_comb begin
    rbuf_nxt = rbuf;
    if (pend)
      rbuf_nxt[{pidx, 3'b000} +: 8] = mem_din;
  end

  // transfer FSM: grant, byte sequencing, completion pulse
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state     <= IDLE;
      rr_ptr    <= CW'(NCH - 1);
      ch        <= '0;
      addr      <= '0;
      dat       <= '0;
      wr        <= 1'b0;
      idx       <= '0;
      last      <= '0;
      pend      <= 1'b0;
      pidx      <= '0;
      rbuf      <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= '0;
      pend      <= 1'b0;
      if (pend)
        rbuf <= rbuf_nxt;
      unique case (state)
        IDLE: begin
          if (|gnt) begin
            addr   <= sel_addr;
            dat    <= sel_data;
            wr     <= sel_wr;
            last   <= sel_last;
            ch     <= gnt_ch;
            rr_ptr <= gnt_ch;
            idx    <= '0;
            rbuf   <= '0;
            state  <= XFER;
          end
        end
        XFER: begin
          if (abort) begin
            state <= IDLE;
          end else if (rdy_in) begin
            if (wr) begin
              if (!io_stall) begin
                if (idx == last) begin
                  state         <= IDLE;
                  rsp_valid[ch] <= 1'b1;
                  rsp_data      <= '0;
                end else begin
                  idx <= idx + 2'd1;
                end
              end
            end else begin
              pend <= 1'b1;
              pidx <= idx;
              if (idx == last)
                state <= LAST;
              else
                idx <= idx + 2'd1;
            end
          end
        end
        LAST: begin
          if (abort) begin
            state <= IDLE;
          end else if (rdy_in) begin
            state         <= IDLE;
            rsp_valid[ch] <= 1'b1;
            rsp_data      <= rbuf_nxt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter_nch.sv
// tb_mem_arbiter_nch: random + directed bench for mem_arbiter_nch
// transaction-level reference model, byte memory model
module tb_mem_arbiter_nch;

  localparam int NCH = 3;
  localparam logic [NCH-1:0] MASK = 3'b011;

  logic              clk_in = 1'b0;
  logic              rst_in;
  logic              rdy_in;
  logic              clr_in;
  logic              io_buffer_full;
  logic [7:0]        mem_din;
  logic [7:0]        mem_dout;
  logic [31:0]       mem_a;
  logic              mem_wr;
  logic [NCH-1:0]    req_valid;
  logic [NCH-1:0]    req_wr;
  logic [2*NCH-1:0]  req_len;
  logic [32*NCH-1:0] req_addr;
  logic [32*NCH-1:0] req_data;
  logic [NCH-1:0]    req_ready;
  logic [NCH-1:0]    rsp_valid;
  logic [31:0]       rsp_data;
  logic              busy;

  always #5 clk_in = ~clk_in;

  mem_arbiter_nch #(
    .NCH(NCH),
    .FLUSH_MASK(MASK)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .rdy_in(rdy_in),
    .clr_in(clr_in),
    .io_buffer_full(io_buffer_full),
    .mem_din(mem_din),
    .mem_dout(mem_dout),
    .mem_a(mem_a),
    .mem_wr(mem_wr),
    .req_valid(req_valid),
    .req_wr(req_wr),
    .req_len(req_len),
    .req_addr(req_addr),
    .req_data(req_data),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_data(rsp_data),
    .busy(busy)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc_n = 0;

  logic [7:0] ram [logic [31:0]];

  // model state: one transaction in flight
  logic           m_act;
  logic           m_wr;
  logic           m_tail;
  logic           m_rdchk;
  int             m_ch;
  int             m_n;
  int             m_k;
  int             m_rr;
  logic [31:0]    m_addr;
  logic [31:0]    m_data;
  logic [31:0]    m_rd;
  logic [NCH-1:0] m_rv;

  logic [NCH-1:0] e_rdy;
  logic [31:0]    e_a;
  logic           e_stall;
  logic           e_mwr;

  logic [31:0] prev_a;
  int          acc_cyc;
  int          rsp_cyc;
  int          acc_q[$];

  function automatic logic [7:0] rd(input logic [31:0] a);
    if (ram.exists(a))
      return ram[a];
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'hA5;
  endfunction

  function automatic int nbytes(input logic [1:0] l);
    if (l == 2'd0) return 1;
    if (l == 2'd1) return 2;
    return 4;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h want=%h cyc=%0d",
               tag, got, exp, cyc_n);
    end
  endtask

  task automatic model_reset();
    m_act   = 1'b0;
    m_tail  = 1'b0;
    m_rdchk = 1'b0;
    m_rr    = NCH - 1;
    m_rv    = '0;
    m_k     = 0;
  endtask

  // compare DUT outputs with the model for the current cycle
  task automatic settle();
    logic fnd;
    int c;
    #2;
    e_rdy   = '0;
    e_a     = '0;
    e_stall = 1'b0;
    e_mwr   = 1'b0;
    if (!rst_in) begin
      model_reset();
    end else begin
      fnd = 1'b0;
      if (!m_act && rdy_in) begin
        for (int i = 1; i <= NCH; i++) begin
          c = (m_rr + i) % NCH;
          if (!fnd && req_valid[c] &&
              !(clr_in && MASK[c] && !req_wr[c])) begin
            fnd = 1'b1;
            e_rdy[c] = 1'b1;
          end
        end
      end
      if (m_act && !m_tail)
        e_a = m_addr + 32'(m_k);
      e_stall = m_act && m_wr && io_buffer_full &&
                (e_a[17:16] == 2'b11);
      e_mwr = m_act && m_wr && rdy_in && !e_stall;
    end
    chk("busy", 32'(busy), 32'(m_act));
    chk("req_ready", 32'(req_ready), 32'(e_rdy));
    chk("mem_wr", 32'(mem_wr), 32'(e_mwr));
    if (!m_act || !m_tail)
      chk("mem_a", mem_a, e_a);
    if (!m_act)
      chk("mem_dout_idle", 32'(mem_dout), 32'd0);
    else if (e_mwr)
      chk("mem_dout", 32'(mem_dout),
          32'(8'(m_data >> (8 * m_k))));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_rv));
    if (|m_rv && m_rdchk)
      chk("rsp_data", rsp_data, m_rd);
    for (int i = 0; i < NCH; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        acc_cyc = cyc_n;
        acc_q.push_back(i);
      end
    end
    if (|rsp_valid)
      rsp_cyc = cyc_n;
    prev_a = mem_a;
  endtask

  // advance the model across the clock edge
  task automatic tick();
    logic [NCH-1:0] nrv;
    int g;
    nrv     = '0;
    m_rdchk = 1'b0;
    if (rst_in) begin
      if (!m_act) begin
        if (|e_rdy) begin
          g = 0;
          for (int i = 0; i < NCH; i++)
            if (e_rdy[i]) g = i;
          m_act  = 1'b1;
          m_ch   = g;
          m_wr   = req_wr[g];
          m_n    = nbytes(req_len[2*g +: 2]);
          m_addr = req_addr[32*g +: 32];
          m_data = req_data[32*g +: 32];
          m_k    = 0;
          m_tail = 1'b0;
          m_rr   = g;
        end
      end else if (clr_in && !m_wr && MASK[m_ch]) begin
        m_act = 1'b0;
      end else if (rdy_in) begin
        if (m_wr) begin
          if (!e_stall) begin
            ram[e_a] = 8'(m_data >> (8 * m_k));
            m_k++;
            if (m_k == m_n) begin
              m_act    = 1'b0;
              nrv[m_ch] = 1'b1;
            end
          end
        end else if (!m_tail) begin
          m_k++;
          if (m_k == m_n) m_tail = 1'b1;
        end else begin
          m_act     = 1'b0;
          m_tail    = 1'b0;
          nrv[m_ch] = 1'b1;
          m_rdchk   = 1'b1;
          m_rd      = '0;
          for (int i = 0; i < m_n; i++)
            m_rd = m_rd |
              (32'(rd(m_addr + 32'(i))) << (8 * i));
        end
      end
    end
    m_rv = nrv;
    @(posedge clk_in);
    #1;
    mem_din = rd(prev_a);
    cyc_n++;
  endtask

  task automatic step();
    settle();
    tick();
  endtask

  task automatic drain();
    int i;
    req_valid      = '0;
    clr_in         = 1'b0;
    rdy_in         = 1'b1;
    io_buffer_full = 1'b0;
    i = 0;
    while ((m_act || |m_rv) && i < 30) begin
      step();
      i++;
    end
    step();
    chk("drain_busy", 32'(busy), 32'd0);
  endtask

  task automatic set_req(input int c, input logic w,
                         input logic [1:0] l,
                         input logic [31:0] a,
                         input logic [31:0] d);
    req_wr[c]          = w;
    req_len[2*c +: 2]  = l;
    req_addr[32*c +: 32] = a;
    req_data[32*c +: 32] = d;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] wa [4];
    int na;
    rst_in         = 1'b0;
    rdy_in         = 1'b1;
    clr_in         = 1'b0;
    io_buffer_full = 1'b0;
    mem_din        = '0;
    req_valid      = '0;
    req_wr         = '0;
    req_len        = '0;
    req_addr       = '0;
    req_data       = '0;
    prev_a         = '0;
    acc_cyc        = 0;
    rsp_cyc        = 0;
    model_reset();
    #1;
    step();
    step();
    rst_in = 1'b1;
    step();

    // reset in the middle of a write
    set_req(0, 1'b1, 2'd2, 32'h100, 32'hCAFEF00D);
    req_valid = 3'b001;
    step();
    req_valid = '0;
    settle();
    chk("w_before", 32'(mem_wr), 32'd1);
    tick();
    rst_in = 1'b0;
    settle();
    chk("rst_mwr", 32'(mem_wr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp", 32'(rsp_valid), 32'd0);
    tick();
    rst_in = 1'b1;
    for (int c = 0; c < NCH; c++)
      set_req(c, 1'b0, 2'd0, 32'h10 * c, 32'd0);
    req_valid = 3'b111;
    settle();
    chk("rst_first", 32'(req_ready), 32'h1);
    tick();
    drain();

    // 4-byte read, known bytes
    ram[32'h100] = 8'h11;
    ram[32'h101] = 8'h22;
    ram[32'h102] = 8'h33;
    ram[32'h103] = 8'h44;
    set_req(0, 1'b0, 2'd2, 32'h100, 32'd0);
    req_valid = 3'b001;
    settle();
    chk("rd4_acc", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    for (int k = 0; k < 4; k++) begin
      settle();
      chk("rd4_a", mem_a, 32'h100 + 32'(k));
      tick();
    end
    settle();
    chk("rd4_early", 32'(rsp_valid), 32'd0);
    tick();
    settle();
    chk("rd4_rsp", 32'(rsp_valid), 32'h1);
    chk("rd4_data", rsp_data, 32'h44332211);
    tick();
    drain();

    // round-robin alternation, rr currently at ch0
    set_req(0, 1'b0, 2'd0, 32'h200, 32'd0);
    set_req(1, 1'b0, 2'd0, 32'h300, 32'd0);
    acc_q.delete();
    req_valid = 3'b011;
    for (int k = 0; k < 16; k++) step();
    chk("alt_cnt", 32'(acc_q.size() >= 4), 32'd1);
    na = (acc_q.size() < 4) ? acc_q.size() : 4;
    for (int k = 0; k < na; k++)
      chk("alt_ch", 32'(acc_q[k]), (k % 2 == 0) ? 32'd1 : 32'd0);
    drain();

    // IO write with buffer full for three cycles
    set_req(1, 1'b1, 2'd0, 32'h30000, 32'h41);
    req_valid = 3'b010;
    settle();
    chk("io_acc", 32'(req_ready), 32'h2);
    tick();
    req_valid      = '0;
    io_buffer_full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("io_stall", 32'(mem_wr), 32'd0);
      tick();
    end
    io_buffer_full = 1'b0;
    settle();
    chk("io_wr", 32'(mem_wr), 32'd1);
    chk("io_a", mem_a, 32'h30000);
    chk("io_dout", 32'(mem_dout), 32'h41);
    tick();
    settle();
    chk("io_rsp", 32'(rsp_valid), 32'h2);
    tick();
    drain();

    // flush aborts a masked read
    set_req(0, 1'b0, 2'd2, 32'h400, 32'd0);
    req_valid = 3'b001;
    step();
    req_valid = '0;
    step();
    clr_in = 1'b1;
    step();
    clr_in = 1'b0;
    settle();
    chk("clr_busy", 32'(busy), 32'd0);
    tick();
    for (int k = 0; k < 4; k++) begin
      settle();
      chk("clr_norsp", 32'(rsp_valid), 32'd0);
      tick();
    end

    // flush never aborts a write
    set_req(1, 1'b1, 2'd1, 32'h500, 32'hBEEF);
    req_valid = 3'b010;
    step();
    req_valid = '0;
    clr_in    = 1'b1;
    step();
    clr_in = 1'b0;
    step();
    settle();
    chk("clrw_rsp", 32'(rsp_valid), 32'h2);
    tick();
    drain();

    // unmasked channel reads survive a flush
    set_req(0, 1'b0, 2'd0, 32'h600, 32'd0);
    set_req(2, 1'b0, 2'd0, 32'h700, 32'd0);
    req_valid = 3'b101;
    clr_in    = 1'b1;
    settle();
    chk("mask_acc", 32'(req_ready), 32'h4);
    tick();
    req_valid = '0;
    step();
    step();
    settle();
    chk("mask_rsp", 32'(rsp_valid), 32'h4);
    tick();
    drain();

    // pause during a wrapping 4-byte write
    set_req(0, 1'b1, 2'd2, 32'hFFFF_FFFE, 32'hDDCCBBAA);
    req_valid = 3'b001;
    step();
    req_valid = '0;
    settle();
    chk("wrap_a0", mem_a, 32'hFFFF_FFFE);
    chk("wrap_d0", 32'(mem_dout), 32'hAA);
    tick();
    rdy_in = 1'b0;
    for (int k = 0; k < 2; k++) begin
      settle();
      chk("wrap_pause", 32'(mem_wr), 32'd0);
      tick();
    end
    rdy_in = 1'b1;
    wa[0] = 32'hFFFF_FFFF;
    wa[1] = 32'h0;
    wa[2] = 32'h1;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("wrap_a", mem_a, wa[k]);
      chk("wrap_wr", 32'(mem_wr), 32'd1);
      tick();
    end
    settle();
    chk("wrap_rsp", 32'(rsp_valid), 32'h1);
    tick();
    drain();

    // randomized traffic
    for (int n = 0; n < 2500; n++) begin
      req_valid = NCH'($urandom);
      for (int c = 0; c < NCH; c++) begin
        logic [31:0] a;
        case ($urandom_range(0, 3))
          0: a = $urandom;
          1: a = 32'h0003_0000 | ($urandom & 32'hFFFF);
          2: a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
          default: a = 32'h0002_FFFE + 32'($urandom_range(0, 3));
        endcase
        set_req(c, ($urandom_range(0, 2) == 0),
                2'($urandom), a, $urandom);
      end
      rdy_in         = ($urandom_range(0, 9) != 0);
      clr_in         = ($urandom_range(0, 11) == 0);
      io_buffer_full = ($urandom_range(0, 2) == 0);
      rst_in         = ($urandom_range(0, 399) != 0);
      step();
    end
    rst_in = 1'b1;
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
